// File: rtl/cpu_param_pkg.sv
// Shared constants for the parametrised accumulator CPU.
// Holds the opcode map, the JMP condition codes and the FSM state encoding.
package cpu_param_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_LDB  = 4'h4;
    localparam logic [3:0] OP_STB  = 4'h5;
    localparam logic [3:0] OP_LDC  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_SWAP = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LDCB = 4'hA;
    localparam logic [3:0] OP_AND  = 4'hB;
    localparam logic [3:0] OP_OR   = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] CC_ALWAYS = 4'h0;
    localparam logic [3:0] CC_Z      = 4'h1;
    localparam logic [3:0] CC_NZ     = 4'h2;
    localparam logic [3:0] CC_C      = 4'h3;
    localparam logic [3:0] CC_NC     = 4'h4;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_EXECUTE   = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_HALT      = 3'd3
    } state_e;

endpackage

// File: rtl/cpu_alu_param.sv
// Combinational ALU for the accumulator CPU.
// Ports:
//   op_i     : opcode of the instruction being executed
//   a_i, b_i : operands (A op B)
//   result_o : result truncated to DATA_W
//   zero_o   : result == 0
//   carry_o  : carry-out for ADD, borrow (A<B) for SUB, 0 otherwise
module cpu_alu_param
    import cpu_param_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum      = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/param_cpu_core.sv
// Parametrised accumulator CPU core with return stack.
// Instruction word: {opcode[3:0], cond[3:0], operand[DATA_W-1:0]}.
//
// state      | meaning
// FETCH      | latch IR from imem_data, PC <= PC+1
// EXECUTE    | perform the instruction held in IR
// LOAD_WAIT  | capture dmem_rdata into A or B
// HALT       | stopped until reset
//
// Ports:
//   clk, rst (async, active-high), run (low freezes all state)
//   imem_addr/imem_data : instruction fetch (combinational read)
//   dmem_addr/dmem_we/dmem_wdata/dmem_rdata : data memory (1-cycle read)
//   dbg_a, dbg_b, dbg_pc, dbg_state, dbg_flags {C,Z}, halted, fault
module param_cpu_core
    import cpu_param_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int INSTR_W    = DATA_W + 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  dbg_a,
    output logic [DATA_W-1:0]  dbg_b,
    output logic [ADDR_W-1:0]  dbg_pc,
    output logic [2:0]         dbg_state,
    output logic [1:0]         dbg_flags,
    output logic               halted,
    output logic               fault
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               c_q;
    logic               z_q;
    logic [SP_W-1:0]    sp_q;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic               halted_q;
    logic               fault_q;

    logic [3:0]        opcode;
    logic [3:0]        cond;
    logic [DATA_W-1:0] operand;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [SP_W-1:0]   sp_inc_d;
    logic [SP_W-1:0]   sp_dec_d;
    logic              jump_take;
    logic              stack_full;
    logic              stack_empty;
    logic              is_store;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;

    assign opcode      = ir_q[INSTR_W-1 -: 4];
    assign cond        = ir_q[DATA_W+3 -: 4];
    assign operand     = ir_q[DATA_W-1:0];
    assign target      = operand[ADDR_W-1:0];
    assign pc_inc_d    = pc_q + 1'b1;
    assign sp_inc_d    = sp_q + 1'b1;
    assign sp_dec_d    = sp_q - 1'b1;
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign is_store    = (opcode == OP_STA) || (opcode == OP_STB);

    always_comb begin
        jump_take = 1'b0;
        case (cond)
            CC_ALWAYS: jump_take = 1'b1;
            CC_Z:      jump_take = z_q;
            CC_NZ:     jump_take = ~z_q;
            CC_C:      jump_take = c_q;
            CC_NC:     jump_take = ~c_q;
            default:   jump_take = 1'b0;
        endcase
    end

    cpu_alu_param #(.DATA_W(DATA_W)) u_alu (
        .op_i     (opcode),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            sp_q     <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (run) begin
            case (state_q)
                ST_FETCH: begin
                    ir_q    <= imem_data;
                    pc_q    <= pc_inc_d;
                    state_q <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    state_q <= ST_FETCH;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            a_q <= alu_result;
                            z_q <= alu_zero;
                            c_q <= alu_carry;
                        end
                        OP_LDA, OP_LDB: state_q <= ST_LOAD_WAIT;
                        OP_LDC:  a_q <= operand;
                        OP_LDCB: b_q <= operand;
                        OP_SWAP: begin
                            a_q <= b_q;
                            b_q <= a_q;
                        end
                        OP_JMP: begin
                            if (jump_take) pc_q <= target;
                        end
                        OP_CALL: begin
                            if (stack_full) begin
                                fault_q  <= 1'b1;
                                halted_q <= 1'b1;
                                state_q  <= ST_HALT;
                            end else begin
                                // PC already points past the CALL, so it is the return address.
                                stack_q[sp_q[IDX_W-1:0]] <= pc_q;
                                sp_q <= sp_inc_d;
                                pc_q <= target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                fault_q  <= 1'b1;
                                halted_q <= 1'b1;
                                state_q  <= ST_HALT;
                            end else begin
                                pc_q <= stack_q[sp_dec_d[IDX_W-1:0]];
                                sp_q <= sp_dec_d;
                            end
                        end
                        OP_HLT: begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                        default: state_q <= ST_FETCH;
                    endcase
                end
                ST_LOAD_WAIT: begin
                    if (opcode == OP_LDA) a_q <= dmem_rdata;
                    else                  b_q <= dmem_rdata;
                    state_q <= ST_FETCH;
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = target;
    // Store strobe is combinational so it drops immediately on reset or run=0.
    assign dmem_we    = run && (state_q == ST_EXECUTE) && is_store;
    assign dmem_wdata = (opcode == OP_STB) ? b_q : a_q;
    assign dbg_a      = a_q;
    assign dbg_b      = b_q;
    assign dbg_pc     = pc_q;
    assign dbg_state  = state_q;
    assign dbg_flags  = {c_q, z_q};
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_param_cpu_core.sv
module tb_param_cpu_core;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, LDA = 4'h2, STA = 4'h3, LDB = 4'h4;
    localparam logic [3:0] LDC = 4'h6, JMP = 4'h7, SWAP = 4'h8, XOR = 4'h9, LDCB = 4'hA;
    localparam logic [3:0] AND = 4'hB, OR = 4'hC, CALL = 4'hD, RET = 4'hE, HLT = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  dmem_addr;
    logic        dmem_we;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata;
    logic [7:0]  dbg_a, dbg_b, dbg_pc;
    logic [2:0]  dbg_state;
    logic [1:0]  dbg_flags;
    logic        halted, fault;

    int errors = 0;
    int checks = 0;

    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    logic [7:0]  rd_addr_q = '0;
    int          wr_count = 0;

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[rd_addr_q];

    always @(posedge clk) begin
        if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            wr_count <= wr_count + 1;
        end
        rd_addr_q <= dmem_addr;
    end

    param_cpu_core #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_pc(dbg_pc), .dbg_state(dbg_state),
        .dbg_flags(dbg_flags), .halted(halted), .fault(fault)
    );

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] cc, input logic [7:0] opd);
        return {op, cc, opd};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = ins(HLT, 4'h0, 8'h00);
    endtask

    // Reset over one clock, then release at a falling edge with run high.
    task automatic start();
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0;
        cyc(2);
        checks++; if (dbg_pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", dbg_pc); end
        checks++; if (dbg_a !== 8'h00 || dbg_b !== 8'h00) begin errors++; $display("FAIL reset_ab: got %h %h expected 00 00", dbg_a, dbg_b); end
        checks++; if (dbg_state !== 3'd0 || dbg_flags !== 2'b00) begin errors++; $display("FAIL reset_state_flags: got %0d %b expected 0 00", dbg_state, dbg_flags); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_status: got h=%b f=%b we=%b expected 0 0 0", halted, fault, dmem_we); end
    endtask

    task automatic test_arith();
        clear_prog();
        imem[0] = ins(LDC, 4'h0, 8'h05);
        imem[1] = ins(LDCB, 4'h0, 8'h03);
        imem[2] = ins(ADD, 4'h0, 8'h00);
        imem[3] = ins(SUB, 4'h0, 8'h00);
        imem[4] = ins(LDCB, 4'h0, 8'h09);
        imem[5] = ins(SUB, 4'h0, 8'h00);
        imem[6] = ins(HLT, 4'h0, 8'h00);
        start();
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL first_fetch_addr: got %h expected 00", imem_addr); end
        cyc(8);
        checks++; if (dbg_a !== 8'h05) begin errors++; $display("FAIL arith_a: got %h expected 05", dbg_a); end
        checks++; if (dbg_flags !== 2'b00) begin errors++; $display("FAIL arith_flags: got %b expected 00", dbg_flags); end
        checks++; if (dbg_pc !== 8'h04 || dbg_state !== 3'd0) begin errors++; $display("FAIL arith_pc_state: got %h %0d expected 04 0", dbg_pc, dbg_state); end
        cyc(4);
        checks++; if (dbg_a !== 8'hFC) begin errors++; $display("FAIL borrow_a: got %h expected fc", dbg_a); end
        checks++; if (dbg_flags !== 2'b10) begin errors++; $display("FAIL borrow_flags: got %b expected 10", dbg_flags); end
        cyc(2);
        checks++; if (halted !== 1'b1 || dbg_state !== 3'd3 || fault !== 1'b0) begin errors++; $display("FAIL hlt: got h=%b st=%0d f=%b expected 1 3 0", halted, dbg_state, fault); end
        cyc(3);
        checks++; if (dbg_pc !== 8'h07 || halted !== 1'b1) begin errors++; $display("FAIL hlt_stays: got pc=%h h=%b expected 07 1", dbg_pc, halted); end
    endtask

    task automatic test_logic();
        clear_prog();
        imem[0]  = ins(LDC, 4'h0, 8'hFF);
        imem[1]  = ins(LDCB, 4'h0, 8'h01);
        imem[2]  = ins(ADD, 4'h0, 8'h00);
        imem[3]  = ins(LDC, 4'h0, 8'hC5);
        imem[4]  = ins(LDCB, 4'h0, 8'h0F);
        imem[5]  = ins(AND, 4'h0, 8'h00);
        imem[6]  = ins(XOR, 4'h0, 8'h00);
        imem[7]  = ins(OR, 4'h0, 8'h00);
        imem[8]  = ins(LDCB, 4'h0, 8'hF0);
        imem[9]  = ins(SWAP, 4'h0, 8'h00);
        imem[10] = ins(AND, 4'h0, 8'h00);
        start();
        cyc(12);
        checks++; if (dbg_a !== 8'h05 || dbg_flags !== 2'b00) begin errors++; $display("FAIL and_clears_c: got a=%h f=%b expected 05 00", dbg_a, dbg_flags); end
        cyc(2);
        checks++; if (dbg_a !== 8'h0A) begin errors++; $display("FAIL xor_a: got %h expected 0a", dbg_a); end
        cyc(2);
        checks++; if (dbg_a !== 8'h0F) begin errors++; $display("FAIL or_a: got %h expected 0f", dbg_a); end
        cyc(4);
        checks++; if (dbg_a !== 8'hF0 || dbg_b !== 8'h0F) begin errors++; $display("FAIL swap: got %h %h expected f0 0f", dbg_a, dbg_b); end
        cyc(2);
        checks++; if (dbg_a !== 8'h00 || dbg_flags !== 2'b01) begin errors++; $display("FAIL and_zero: got a=%h f=%b expected 00 01", dbg_a, dbg_flags); end
    endtask

    task automatic test_jump();
        clear_prog();
        imem[8'h00] = ins(LDC, 4'h0, 8'hFF);
        imem[8'h01] = ins(LDCB, 4'h0, 8'h01);
        imem[8'h02] = ins(ADD, 4'h0, 8'h00);
        imem[8'h03] = ins(JMP, 4'h1, 8'h20);
        imem[8'h20] = ins(JMP, 4'h2, 8'h40);
        imem[8'h21] = ins(JMP, 4'h3, 8'h30);
        imem[8'h30] = ins(JMP, 4'h4, 8'h50);
        imem[8'h31] = ins(JMP, 4'h0, 8'h60);
        imem[8'h60] = ins(JMP, 4'h5, 8'h70);
        start();
        cyc(6);
        checks++; if (dbg_a !== 8'h00 || dbg_flags !== 2'b11) begin errors++; $display("FAIL add_carry: got a=%h f=%b expected 00 11", dbg_a, dbg_flags); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h20) begin errors++; $display("FAIL jmp_z: got %h expected 20", dbg_pc); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h21) begin errors++; $display("FAIL jmp_nz_not_taken: got %h expected 21", dbg_pc); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h30) begin errors++; $display("FAIL jmp_c: got %h expected 30", dbg_pc); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h31) begin errors++; $display("FAIL jmp_nc_not_taken: got %h expected 31", dbg_pc); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h60) begin errors++; $display("FAIL jmp_always: got %h expected 60", dbg_pc); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h61 || dbg_flags !== 2'b11) begin errors++; $display("FAIL jmp_cond5: got pc=%h f=%b expected 61 11", dbg_pc, dbg_flags); end
    endtask

    task automatic test_mem();
        int we_cnt;
        clear_prog();
        imem[0] = ins(LDC, 4'h0, 8'h07);
        imem[1] = ins(STA, 4'h0, 8'd100);
        imem[2] = ins(LDB, 4'h0, 8'd100);
        start();
        we_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (dmem_we === 1'b1) we_cnt++;
            if (i == 3) begin
                checks++; if (dmem_we !== 1'b1 || dmem_addr !== 8'd100 || dmem_wdata !== 8'h07) begin errors++; $display("FAIL sta_strobe: got we=%b addr=%0d wd=%h expected 1 100 07", dmem_we, dmem_addr, dmem_wdata); end
            end
            if (i == 6) begin
                checks++; if (dbg_state !== 3'd2 || dmem_we !== 1'b0) begin errors++; $display("FAIL ldb_wait: got st=%0d we=%b expected 2 0", dbg_state, dmem_we); end
            end
            if (i == 7) begin
                checks++; if (dbg_b !== 8'h07 || dbg_state !== 3'd0 || dbg_pc !== 8'h03) begin errors++; $display("FAIL ldb_done: got b=%h st=%0d pc=%h expected 07 0 03", dbg_b, dbg_state, dbg_pc); end
            end
        end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL we_pulse_count: got %0d expected 1", we_cnt); end
    endtask

    task automatic test_stack();
        clear_prog();
        imem[8'h00] = ins(CALL, 4'h0, 8'h10);
        imem[8'h01] = ins(LDC, 4'h0, 8'h33);
        imem[8'h10] = ins(LDCB, 4'h0, 8'h44);
        imem[8'h11] = ins(RET, 4'h0, 8'h00);
        start();
        cyc(2);
        checks++; if (dbg_pc !== 8'h10) begin errors++; $display("FAIL call_pc: got %h expected 10", dbg_pc); end
        cyc(4);
        checks++; if (dbg_pc !== 8'h01 || dbg_b !== 8'h44) begin errors++; $display("FAIL ret_pc: got pc=%h b=%h expected 01 44", dbg_pc, dbg_b); end
        cyc(4);
        checks++; if (dbg_a !== 8'h33 || halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL call_ret_end: got a=%h h=%b f=%b expected 33 1 0", dbg_a, halted, fault); end

        clear_prog();
        imem[8'h00] = ins(CALL, 4'h0, 8'h10);
        imem[8'h10] = ins(CALL, 4'h0, 8'h20);
        imem[8'h20] = ins(CALL, 4'h0, 8'h30);
        imem[8'h30] = ins(CALL, 4'h0, 8'h40);
        imem[8'h40] = ins(CALL, 4'h0, 8'h50);
        start();
        cyc(8);
        checks++; if (dbg_pc !== 8'h40 || fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL call4: got pc=%h f=%b h=%b expected 40 0 0", dbg_pc, fault, halted); end
        cyc(2);
        checks++; if (fault !== 1'b1 || halted !== 1'b1 || dbg_pc !== 8'h41 || dbg_state !== 3'd3) begin errors++; $display("FAIL call_overflow: got f=%b h=%b pc=%h st=%0d expected 1 1 41 3", fault, halted, dbg_pc, dbg_state); end

        clear_prog();
        imem[0] = ins(RET, 4'h0, 8'h00);
        start();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_clears_fault: got %b expected 0", fault); end
        cyc(2);
        checks++; if (fault !== 1'b1 || halted !== 1'b1 || dbg_pc !== 8'h01) begin errors++; $display("FAIL ret_underflow: got f=%b h=%b pc=%h expected 1 1 01", fault, halted, dbg_pc); end
    endtask

    task automatic test_wrap_hold();
        int w0;
        clear_prog();
        imem[8'h00] = ins(JMP, 4'h0, 8'hFF);
        imem[8'hFF] = ins(LDC, 4'h0, 8'h5A);
        start();
        cyc(2);
        checks++; if (dbg_pc !== 8'hFF) begin errors++; $display("FAIL wrap_pre: got %h expected ff", dbg_pc); end
        cyc(2);
        checks++; if (dbg_pc !== 8'h00 || dbg_a !== 8'h5A) begin errors++; $display("FAIL wrap_pc: got pc=%h a=%h expected 00 5a", dbg_pc, dbg_a); end

        clear_prog();
        imem[0] = ins(LDC, 4'h0, 8'h09);
        imem[1] = ins(LDCB, 4'h0, 8'h04);
        imem[2] = ins(STA, 4'h0, 8'h10);
        imem[3] = ins(ADD, 4'h0, 8'h00);
        start();
        cyc(5);
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL hold_pre_we: got %b expected 1", dmem_we); end
        w0 = wr_count;
        run = 1'b0;
        #1;
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL hold_we_drop: got %b expected 0", dmem_we); end
        cyc(5);
        checks++; if (dbg_a !== 8'h09 || dbg_b !== 8'h04 || dbg_pc !== 8'h03 || dbg_state !== 3'd1) begin errors++; $display("FAIL hold_regs: got a=%h b=%h pc=%h st=%0d expected 09 04 03 1", dbg_a, dbg_b, dbg_pc, dbg_state); end
        checks++; if (wr_count !== w0 || dmem_we !== 1'b0) begin errors++; $display("FAIL hold_no_write: got writes=%0d we=%b expected %0d 0", wr_count, dmem_we, w0); end
        run = 1'b1;
        cyc(1);
        checks++; if (wr_count !== w0 + 1 || dmem[8'h10] !== 8'h09) begin errors++; $display("FAIL hold_resume_store: got writes=%0d mem=%h expected %0d 09", wr_count, dmem[8'h10], w0 + 1); end
        cyc(2);
        checks++; if (dbg_a !== 8'h0D || dbg_flags !== 2'b00) begin errors++; $display("FAIL hold_resume_add: got a=%h f=%b expected 0d 00", dbg_a, dbg_flags); end
    endtask

    task automatic test_async_reset();
        clear_prog();
        imem[0] = ins(LDC, 4'h0, 8'h11);
        imem[1] = ins(LDA, 4'h0, 8'h05);
        imem[2] = ins(HLT, 4'h0, 8'h00);
        start();
        cyc(4);
        checks++; if (dbg_state !== 3'd2) begin errors++; $display("FAIL pre_rst_loadwait: got %0d expected 2", dbg_state); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dbg_state !== 3'd0 || dbg_pc !== 8'h00 || imem_addr !== 8'h00 || dmem_addr !== 8'h00) begin errors++; $display("FAIL rst_loadwait_ctl: got st=%0d pc=%h ia=%h da=%h expected 0 00 00 00", dbg_state, dbg_pc, imem_addr, dmem_addr); end
        checks++; if (dbg_a !== 8'h00 || dbg_b !== 8'h00 || dmem_we !== 1'b0) begin errors++; $display("FAIL rst_loadwait_data: got a=%h b=%h we=%b expected 00 00 0", dbg_a, dbg_b, dmem_we); end
        start();
        cyc(7);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL pre_rst_halt: got %b expected 1", halted); end
        #2 rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0 || fault !== 1'b0 || dbg_state !== 3'd0 || dbg_pc !== 8'h00 || dbg_a !== 8'h00 || dbg_flags !== 2'b00) begin errors++; $display("FAIL rst_halt: got h=%b f=%b st=%0d pc=%h a=%h fl=%b expected 0 0 0 00 00 00", halted, fault, dbg_state, dbg_pc, dbg_a, dbg_flags); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_prog();
        test_reset();
        test_arith();
        test_logic();
        test_jump();
        test_mem();
        test_stack();
        test_wrap_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_cpu_core.md
PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning accumulator/register/data-bus width (legal 8..32).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning program/data address width (legal 4..DATA_W).
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries (legal 2..16).
REQ-004 The block SHALL have derived localparam INSTR_W = DATA_W+8, with instruction format {opcode[3:0], cond[3:0], operand[DATA_W-1:0]}.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 run  input  1  high: FSM advances; low: all architectural state holds.
REQ-008 imem_addr  output  ADDR_W  program address, equals PC.
REQ-009 imem_data  input  INSTR_W  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-010 dmem_addr  output  ADDR_W  equals IR operand[ADDR_W-1:0].
REQ-011 dmem_we  output  1  write strobe.
REQ-012 dmem_wdata  output  DATA_W  write data.
REQ-013 dmem_rdata  input  DATA_W  read data, valid one cycle after dmem_addr is presented.
REQ-014 dbg_a, dbg_b  output  DATA_W  registers A and B; dbg_pc  output  ADDR_W  PC.
REQ-015 dbg_state  output  3  FSM encoding; dbg_flags  output  2  {C,Z}; halted  output  1; fault  output  1.

Function
REQ-016 The FSM SHALL have states FETCH=0, EXECUTE=1, LOAD_WAIT=2, HALT=3.
REQ-017 FETCH SHALL load IR from imem_data, set PC to (PC+1) mod 2^ADDR_W, and go to EXECUTE.
REQ-018 Opcodes SHALL be: 0 ADD, 1 SUB, 2 LDA, 3 STA, 4 LDB, 5 STB, 6 LDC, 7 JMP, 8 SWAP, 9 XOR, A LDCB, B AND, C OR, D CALL, E RET, F HLT.
REQ-019 ADD/SUB/AND/OR/XOR SHALL write the ALU result of A op B to A and update Z (result==0) and C, all in EXECUTE.
REQ-020 C SHALL be the carry-out for ADD, the borrow (A<B, unsigned) for SUB, and 0 for logical ops; other opcodes leave flags unchanged.
REQ-021 LDC/LDCB SHALL load operand into A/B; SWAP SHALL exchange A and B in one edge.
REQ-022 STA/STB SHALL drive dmem_we=1 and dmem_wdata=A/B combinationally only while in EXECUTE; dmem_we is 0 in every other state and opcode.
REQ-023 LDA/LDB SHALL move EXECUTE->LOAD_WAIT, capture dmem_rdata into A/B in LOAD_WAIT, then go to FETCH (3 cycles total); all other non-halting ops take 2 cycles.
REQ-024 JMP SHALL load PC with operand[ADDR_W-1:0] when cond is satisfied: 0 always, 1 Z=1, 2 Z=0, 3 C=1, 4 C=0; other cond values never jump.
REQ-025 CALL SHALL push the already-incremented PC onto the return stack and jump to operand; RET SHALL pop into PC.
REQ-026 CALL with stack full or RET with stack empty SHALL not modify PC or stack, and SHALL set fault=1 and enter HALT.
REQ-027 HLT SHALL enter HALT; HALT SHALL be left only by reset; halted=1 exactly while in HALT.
REQ-028 With run=0, the FSM SHALL hold its state and all registers, and dmem_we SHALL be 0.
REQ-029 PC increment and jump targets SHALL wrap modulo 2^ADDR_W; ALU results SHALL be truncated to DATA_W.

Reset
REQ-030 rst=1 SHALL immediately force PC, A, B, IR, flags, and stack pointer to 0, state to FETCH, and halted, fault, and dmem_we to 0, including mid-instruction or in HALT.
REQ-031 The first fetch after rst deasserts SHALL read address 0.

Structure
REQ-032 Package cpu_param_pkg SHALL hold opcode, cond-code, and FSM-state constants.
REQ-033 The ALU SHALL be a sub-module cpu_alu_param parametrised by DATA_W, outputting result, zero, and carry.
REQ-034 The return stack SHALL be an internal register array of STACK_DEPTH entries with a pointer; no separate module is needed.

Verification
REQ-035 Program LDC 5; LDCB 3; ADD; SUB SHALL end with A=5, Z=0, C=0 after 8 cycles; after LDCB 9 and SUB: A=0xFC, C=1.
REQ-036 LDC 0xFF; LDCB 1; ADD SHALL give A=0, Z=1, C=1; then JMP cond=1 to 0x20 SHALL give PC=0x20; JMP cond=2 SHALL not jump.
REQ-037 STA 100 with A=7, then LDB 100 SHALL pulse dmem_we for one cycle at address 100 and give B=7, with the LDB taking 3 cycles.
REQ-038 STACK_DEPTH=4: five nested CALLs SHALL set fault=1 and halted=1 on the fifth CALL; a RET at reset (stack empty) SHALL also fault.
REQ-039 PC at 2^ADDR_W-1 executing a non-jump SHALL wrap PC to 0; run=0 for 5 cycles mid-program SHALL change no register.
REQ-040 Asserting rst in LOAD_WAIT and in HALT SHALL return all outputs to reset values without waiting for a clock edge.
